// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID pipeline register layout for the fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// F1 program counter: async reset to RESET_PC, branch load, stall hold, else +4 (mod 2^32).
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Branch wins over stall so a redirect is never lost while the pipe is held.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (!stall) begin
            pc_d = pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Two-stage instruction fetch (F1 address, F2 data) feeding the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_count / bubble_count outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    logic [31:0] pc_f;
    logic [31:0] pc_f2_d, pc_f2_q;
    logic        valid_f2_d, valid_f2_q;
    logic [31:0] hold_buf_d, hold_buf_q;
    logic        hold_valid_d, hold_valid_q;
    if_id_t      if_id_d, if_id_q;
    logic [31:0] f2_instr;
    logic        load_if_id;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall_f),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc_o         (pc_f)
    );

    // The memory moves on to the next address while stalled, so the F2 word is parked in hold_buf.
    assign f2_instr = hold_valid_q ? hold_buf_q : imem_rdata;

    always_comb begin
        pc_f2_d      = pc_f2_q;
        valid_f2_d   = valid_f2_q;
        hold_buf_d   = hold_buf_q;
        hold_valid_d = hold_valid_q;
        if_id_d      = if_id_q;
        load_if_id   = 1'b0;

        if (branch_taken) begin
            valid_f2_d   = 1'b0;
            hold_valid_d = 1'b0;
            if_id_d      = '{instr: NOP_INSTR, pc: pc_f2_q, pc_plus4: pc_f2_q + PC_INCR, valid: 1'b0};
            load_if_id   = 1'b1;
        end else begin
            if (stall_f) begin
                if (!hold_valid_q) begin
                    hold_buf_d   = imem_rdata;
                    hold_valid_d = 1'b1;
                end
            end else begin
                pc_f2_d      = pc_f;
                valid_f2_d   = 1'b1;
                hold_valid_d = 1'b0;
            end

            if (flush_d) begin
                if_id_d    = '{instr: NOP_INSTR, pc: pc_f2_q, pc_plus4: pc_f2_q + PC_INCR, valid: 1'b0};
                load_if_id = 1'b1;
            end else if (!stall_f) begin
                if_id_d    = '{instr: valid_f2_q ? f2_instr : NOP_INSTR, pc: pc_f2_q,
                               pc_plus4: pc_f2_q + PC_INCR, valid: valid_f2_q};
                load_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f2_q      <= 32'h0;
            valid_f2_q   <= 1'b0;
            hold_buf_q   <= 32'h0;
            hold_valid_q <= 1'b0;
            if_id_q      <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
        end else begin
            pc_f2_q      <= pc_f2_d;
            valid_f2_q   <= valid_f2_d;
            hold_buf_q   <= hold_buf_d;
            hold_valid_q <= hold_valid_d;
            if_id_q      <= if_id_d;
        end
    end

    assign imem_addr  = pc_f;
    assign instr_d    = if_id_q.instr;
    assign pc_d       = if_id_q.pc;
    assign pc_plus4_d = if_id_q.pc_plus4;
    assign valid_d    = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_if_id) begin
            if (if_id_d.valid) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    logic unused_load;
    assign unused_load = load_if_id;
`endif

endmodule
